// File: rtl/conv_kernel_mac_pkg.sv
// conv_kernel_mac_pkg: shared FSM state, width helpers and saturation for the convolution MAC
package conv_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, OUT} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int acc_width(input int bw, input int ks);
        return 2 * bw + clog2(ks) + 1;
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/conv_lane_dot.sv
// conv_lane_dot: LANES signed multipliers summed into one beat's partial dot product
module conv_lane_dot
    import conv_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int LANES    = 5
) (
    input  logic [LANES*BITWIDTH-1:0]                  a,
    input  logic [LANES*BITWIDTH-1:0]                  b,
    output logic signed [2*BITWIDTH+clog2(LANES)-1:0]  dot
);

    localparam int OW = 2 * BITWIDTH + clog2(LANES);

    logic signed [2*BITWIDTH-1:0] prod [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_mul
        assign prod[i] = $signed(a[i*BITWIDTH +: BITWIDTH]) * $signed(b[i*BITWIDTH +: BITWIDTH]);
    end

    // sum all lane products; width leaves room for the carries of LANES terms
    always_comb begin
        dot = '0;
        for (int i = 0; i < LANES; i++) dot = dot + OW'(prod[i]);
    end

endmodule

// File: rtl/conv_kernel_mac.sv
// conv_kernel_mac: time-multiplexed signed convolution MAC with bias, optional ReLU and saturation
module conv_kernel_mac
    import conv_pkg::*;
#(
    parameter int BITWIDTH     = 8,
    parameter int DATACHANNEL  = 3,
    parameter int FILTERHEIGHT = 5,
    parameter int FILTERWIDTH  = 5,
    parameter int LANES        = 5,
    parameter int OUTWIDTH     = 16,
    parameter bit RELU_EN      = 1'b1
) (
    input  logic                                                        clk,
    input  logic                                                        rst_n,
    input  logic                                                        clken,
    input  logic                                                        in_valid,
    output logic                                                        in_ready,
    input  logic [BITWIDTH*DATACHANNEL*FILTERHEIGHT*FILTERWIDTH-1:0]    data,
    input  logic [BITWIDTH*DATACHANNEL*FILTERHEIGHT*FILTERWIDTH-1:0]    weight,
    input  logic signed [BITWIDTH-1:0]                                  bias,
    output logic                                                        out_valid,
    input  logic                                                        out_ready,
    output logic signed [OUTWIDTH-1:0]                                  result,
    output logic                                                        overflow
);

    localparam int KS    = DATACHANNEL * FILTERHEIGHT * FILTERWIDTH;
    localparam int BEATS = KS / LANES;
    localparam int AW    = acc_width(BITWIDTH, KS);
    localparam int LW    = 2 * BITWIDTH + clog2(LANES);
    localparam int CW    = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam int SW    = LANES * BITWIDTH;

    state_t                      state;
    state_t                      state_d;
    logic [CW-1:0]               beat;
    logic signed [AW-1:0]        acc;
    logic [KS*BITWIDTH-1:0]      data_q;
    logic [KS*BITWIDTH-1:0]      weight_q;
    logic signed [BITWIDTH-1:0]  bias_q;
    logic [SW-1:0]               a_sl;
    logic [SW-1:0]               b_sl;
    logic signed [LW-1:0]        dot;
    logic signed [63:0]          sum;
    logic signed [63:0]          relu;
    logic signed [63:0]          sat;

    assign a_sl     = data_q[beat*SW +: SW];
    assign b_sl     = weight_q[beat*SW +: SW];
    assign in_ready = rst_n && state == IDLE;

    conv_lane_dot #(.BITWIDTH(BITWIDTH), .LANES(LANES)) u_dot (
        .a   (a_sl),
        .b   (b_sl),
        .dot (dot)
    );

    // final value: bias added, optional ReLU, then clamp to the output range
    always_comb begin
        sum  = 64'(acc) + 64'(bias_q);
        relu = (RELU_EN && sum < 0) ? 64'sd0 : sum;
        sat  = sat_signed(relu, OUTWIDTH);
    end

    // next state: accept in IDLE, step through beats, finalize once, hold until consumed
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  state_d = in_valid ? ACCUM : IDLE;
            ACCUM: state_d = (beat == CW'(BEATS - 1)) ? FINAL : ACCUM;
            FINAL: state_d = OUT;
            OUT:   state_d = out_ready ? IDLE : OUT;
        endcase
    end

    // state, operand capture, accumulation and output registers; clken freezes everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            acc       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (clken) begin
            state <= state_d;
            unique case (state)
                IDLE: if (in_valid) begin
                    data_q   <= data;
                    weight_q <= weight;
                    bias_q   <= bias;
                    acc      <= '0;
                    beat     <= '0;
                end
                ACCUM: begin
                    acc  <= acc + AW'(dot);
                    beat <= beat + 1'b1;
                end
                FINAL: begin
                    result    <= sat[OUTWIDTH-1:0];
                    overflow  <= sat != relu;
                    out_valid <= 1'b1;
                end
                OUT: if (out_ready) out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_kernel_mac.sv
// tb_conv_kernel_mac: directed checks of timing, ReLU, saturation, backpressure, stall and reset
module tb_conv_kernel_mac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clken = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [71:0] data = '0;
    logic [71:0] weight = '0;
    logic [7:0]  bias = '0;
    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [3:0]  of;
    logic [15:0] res [4];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // 0: LANES=3 ReLU on, 1: LANES=3 ReLU off, 2: LANES=1 (9 beats), 3: LANES=9 (1 beat)
    conv_kernel_mac #(.BITWIDTH(8), .DATACHANNEL(1), .FILTERHEIGHT(3), .FILTERWIDTH(3),
                      .LANES(3), .OUTWIDTH(16), .RELU_EN(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .clken(clken), .in_valid(in_valid), .in_ready(ir[0]),
        .data(data), .weight(weight), .bias(bias), .out_valid(ov[0]), .out_ready(out_ready),
        .result(res[0]), .overflow(of[0]));
    conv_kernel_mac #(.BITWIDTH(8), .DATACHANNEL(1), .FILTERHEIGHT(3), .FILTERWIDTH(3),
                      .LANES(3), .OUTWIDTH(16), .RELU_EN(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .clken(clken), .in_valid(in_valid), .in_ready(ir[1]),
        .data(data), .weight(weight), .bias(bias), .out_valid(ov[1]), .out_ready(out_ready),
        .result(res[1]), .overflow(of[1]));
    conv_kernel_mac #(.BITWIDTH(8), .DATACHANNEL(1), .FILTERHEIGHT(3), .FILTERWIDTH(3),
                      .LANES(1), .OUTWIDTH(16), .RELU_EN(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .clken(clken), .in_valid(in_valid), .in_ready(ir[2]),
        .data(data), .weight(weight), .bias(bias), .out_valid(ov[2]), .out_ready(out_ready),
        .result(res[2]), .overflow(of[2]));
    conv_kernel_mac #(.BITWIDTH(8), .DATACHANNEL(1), .FILTERHEIGHT(3), .FILTERWIDTH(3),
                      .LANES(9), .OUTWIDTH(16), .RELU_EN(1'b1)) u_d (
        .clk(clk), .rst_n(rst_n), .clken(clken), .in_valid(in_valid), .in_ready(ir[3]),
        .data(data), .weight(weight), .bias(bias), .out_valid(ov[3]), .out_ready(out_ready),
        .result(res[3]), .overflow(of[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d, input logic [7:0] w, input logic [7:0] b);
        data   = {9{d}};
        weight = {9{w}};
        bias   = b;
    endtask

    task automatic reset_all();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clken     = 1'b1;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (ir[d] !== 1'b0) begin n_err++; $display("FAIL reset_in_ready[%0d] got %b want 0", d, ir[d]); end
            n_cmp++;
            if (ov[d] !== 1'b0 || of[d] !== 1'b0 || res[d] !== 16'd0) begin
                n_err++;
                $display("FAIL reset_outputs[%0d] got ov=%b of=%b res=%0d want 0/0/0", d, ov[d], of[d], res[d]);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (ir[d] !== 1'b1) begin n_err++; $display("FAIL release_in_ready[%0d] got %b want 1", d, ir[d]); end
        end
    endtask

    task automatic test_basic();
        reset_all();
        load(8'd1, 8'd2, 8'hFD);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (ir[0] !== 1'b0) begin n_err++; $display("FAIL basic_busy got in_ready=%b want 0", ir[0]); end
        repeat (3) tick();
        n_cmp++;
        if (ov[0] !== 1'b0) begin n_err++; $display("FAIL basic_early got out_valid=%b want 0", ov[0]); end
        tick();
        n_cmp++;
        if (ov[0] !== 1'b1 || res[0] !== 16'd15 || of[0] !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result got ov=%b res=%0d of=%b want 1/15/0", ov[0], $signed(res[0]), of[0]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || res[0] !== 16'd15) begin
            n_err++;
            $display("FAIL basic_drain got ov=%b ir=%b res=%0d want 0/1/15", ov[0], ir[0], $signed(res[0]));
        end
    endtask

    task automatic test_relu();
        reset_all();
        load(8'd1, 8'hFE, 8'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (ov[0] !== 1'b1 || res[0] !== 16'd0 || of[0] !== 1'b0) begin
            n_err++;
            $display("FAIL relu_on got ov=%b res=%0d of=%b want 1/0/0", ov[0], $signed(res[0]), of[0]);
        end
        n_cmp++;
        if (ov[1] !== 1'b1 || res[1] !== 16'hFFEE || of[1] !== 1'b0) begin
            n_err++;
            $display("FAIL relu_off got ov=%b res=%0d of=%b want 1/-18/0", ov[1], $signed(res[1]), of[1]);
        end
    endtask

    task automatic test_saturation();
        reset_all();
        load(8'd127, 8'd127, 8'd127);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (res[d] !== 16'h7FFF || of[d] !== 1'b1) begin
                n_err++;
                $display("FAIL sat_pos[%0d] got res=%0d of=%b want 32767/1", d, $signed(res[d]), of[d]);
            end
        end
        reset_all();
        load(8'h80, 8'd127, 8'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (res[1] !== 16'h8000 || of[1] !== 1'b1) begin
            n_err++;
            $display("FAIL sat_neg got res=%0d of=%b want -32768/1", $signed(res[1]), of[1]);
        end
        n_cmp++;
        if (res[0] !== 16'd0 || of[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sat_neg_relu got res=%0d of=%b want 0/0", $signed(res[0]), of[0]);
        end
    endtask

    task automatic test_back_to_back();
        reset_all();
        load(8'd1, 8'd2, 8'hFD);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        load(8'd2, 8'd3, 8'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (ov[0] !== 1'b1 || res[0] !== 16'd15 || ir[0] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got ov=%b res=%0d ir=%b want 1/15/0", i, ov[0], $signed(res[0]), ir[0]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release got ov=%b ir=%b want 0/1", ov[0], ir[0]);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (ir[0] !== 1'b0) begin n_err++; $display("FAIL bp_accept got ir=%b want 0", ir[0]); end
        repeat (3) tick();
        n_cmp++;
        if (ov[0] !== 1'b0) begin n_err++; $display("FAIL bp_early got ov=%b want 0", ov[0]); end
        tick();
        n_cmp++;
        if (ov[0] !== 1'b1 || res[0] !== 16'd59 || of[0] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_second got ov=%b res=%0d of=%b want 1/59/0", ov[0], $signed(res[0]), of[0]);
        end
    endtask

    task automatic test_clken_stall();
        reset_all();
        load(8'd1, 8'd2, 8'hFD);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clken = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold got ov=%b ir=%b want 0/0", ov[0], ir[0]);
        end
        clken = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (ov[0] !== 1'b0) begin n_err++; $display("FAIL stall_early got ov=%b want 0", ov[0]); end
        tick();
        n_cmp++;
        if (ov[0] !== 1'b1 || res[0] !== 16'd15) begin
            n_err++;
            $display("FAIL stall_result got ov=%b res=%0d want 1/15", ov[0], $signed(res[0]));
        end
        clken     = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (ov[0] !== 1'b1) begin n_err++; $display("FAIL stall_no_xfer got ov=%b want 1", ov[0]); end
        clken = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (ov[0] !== 1'b0) begin n_err++; $display("FAIL stall_xfer got ov=%b want 0", ov[0]); end
    endtask

    task automatic test_reset_mid();
        int duts [3] = '{0, 2, 3};
        int nbs  [3] = '{3, 9, 1};
        for (int k = 0; k < 3; k++) begin
            int d = duts[k];
            int nb = nbs[k];
            reset_all();
            load(8'd1, 8'd2, 8'hFD);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (nb + 1) tick();
            n_cmp++;
            if (ov[d] !== 1'b1 || res[d] !== 16'd15) begin
                n_err++;
                $display("FAIL mid_first[%0d] got ov=%b res=%0d want 1/15", d, ov[d], $signed(res[d]));
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            load(8'd2, 8'd3, 8'd5);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            #1;
            n_cmp++;
            if (ov[d] !== 1'b0 || res[d] !== 16'd0 || ir[d] !== 1'b1) begin
                n_err++;
                $display("FAIL mid_reset[%0d] got ov=%b res=%0d ir=%b want 0/0/1", d, ov[d], $signed(res[d]), ir[d]);
            end
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (nb) tick();
            n_cmp++;
            if (ov[d] !== 1'b0) begin n_err++; $display("FAIL mid_early[%0d] got ov=%b want 0", d, ov[d]); end
            tick();
            n_cmp++;
            if (ov[d] !== 1'b1 || res[d] !== 16'd59 || of[d] !== 1'b0) begin
                n_err++;
                $display("FAIL mid_result[%0d] got ov=%b res=%0d of=%b want 1/59/0", d, ov[d], $signed(res[d]), of[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_back_to_back();
        test_clken_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
